// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers for the transmit and receive paths.
// Parity support is selected at build time with the UART_TX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Total clock cycles from the start-bit edge to the return to IDLE.
    function automatic int frame_len(input int clks_per_bit, input int stop_bits,
                                     input bit parity_en);
        return (1 + DATA_BITS + (parity_en ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses o_tick on the last count.
// Shared between the UART transmitter and receiver.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_tick = w_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit; PARITY_ODD then selects its sense.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output tx_state_t  dbg_state
);
    // Handshake: a byte is taken at a rising edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE, so tx_valid while busy is simply ignored.

    tx_state_t  r_state;
    logic       r_tx;
    logic [8:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       w_tick;
    logic       w_clr;
    logic       w_par_bit;

`ifdef UART_TX_PARITY_EN
    assign w_par_bit = (^tx_data) ^ PARITY_ODD;
`else
    logic w_unused_par;
    assign w_unused_par = PARITY_ODD;
    assign w_par_bit    = 1'b0;
`endif

    // Held clear in IDLE so START always begins a full bit period; later state
    // entries coincide with the counter wrap, which also lands on zero.
    assign w_clr = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_clr),
        .o_tick(w_tick)
    );

    assign tx_ready  = (r_state == IDLE);
    assign tx_busy   = (r_state != IDLE);
    assign tx        = r_tx;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_valid) begin
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_shift   <= {w_par_bit, tx_data};
                        r_bit_idx <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        // After the last data shift the parity bit sits in bit 0.
                        r_shift   <= {1'b0, r_shift[8:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_shift[1];
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_bit_idx == 3'(STOP_BITS - 1)) begin
                            r_state   <= IDLE;
                            r_bit_idx <= '0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit: three instances cover
// even/1-stop, even/2-stop and odd/1-stop; builds with or without UART_TX_PARITY_EN.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] valid_v = 3'b000;
    logic [2:0] ready_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    tx_state_t  st0, st1, st2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .dbg_state(st0));

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .dbg_state(st1));

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .dbg_state(st2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int d);
        for (int i = 0; i < 200; i++) begin
            if (ready_v[d] === 1'b1) break;
            tick();
        end
        chk($sformatf("ready_timeout_d%0d", d), ready_v[d], 1);
    endtask

    // Handshake at the next edge; returns just after that edge.
    task automatic start_frame(input int d, input logic [7:0] data);
        wait_ready(d);
        tx_data    = data;
        valid_v[d] = 1'b1;
        tick();
        valid_v[d] = 1'b0;
    endtask

    // bits[i] is the i-th transmitted bit; checked every cycle of the frame.
    task automatic check_frame(input int d, input string tag, input logic [11:0] bits,
                               input int len);
        for (int c = 0; c < len; c++) begin
            chk($sformatf("%s_tx_c%0d", tag, c), tx_v[d], bits[c/4]);
            chk($sformatf("%s_busy_c%0d", tag, c), busy_v[d], 1);
            chk($sformatf("%s_ready_c%0d", tag, c), ready_v[d], 0);
            tick();
        end
        chk($sformatf("%s_end_tx", tag), tx_v[d], 1);
        chk($sformatf("%s_end_busy", tag), busy_v[d], 0);
        chk($sformatf("%s_end_ready", tag), ready_v[d], 1);
    endtask

    initial begin
        // Reset and idle
        tick();
        chk("rst_tx", tx_v, 3'b111);
        chk("rst_busy", busy_v, 3'b000);
        chk("rst_ready", ready_v, 3'b111);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("idle_tx_c%0d", c), tx_v, 3'b111);
            chk($sformatf("idle_busy_c%0d", c), busy_v, 3'b000);
            chk($sformatf("idle_ready_c%0d", c), ready_v, 3'b111);
            tick();
        end
        chk("idle_state", st0, IDLE);

        // 0xA5, even parity (popcount 4 -> parity bit 0)
        start_frame(0, 8'hA5);
`ifdef UART_TX_PARITY_EN
        check_frame(0, "a5_even", 12'h54A, 44);
`else
        check_frame(0, "a5_nopar", 12'h34A, 40);
`endif

        // 0xA5 on the odd-parity instance (parity bit 1 when compiled in)
        start_frame(2, 8'hA5);
`ifdef UART_TX_PARITY_EN
        check_frame(2, "a5_odd", 12'h74A, 44);
`else
        check_frame(2, "a5_odd_ignored", 12'h34A, 40);
`endif

        // Back-to-back with tx_valid held; tx_data changes mid-frame
        wait_ready(0);
        tx_data    = 8'h01;
        valid_v[0] = 1'b1;
        tick();
        tx_data = 8'hFF;
`ifdef UART_TX_PARITY_EN
        check_frame(0, "b2b_01", 12'h602, 44);
`else
        check_frame(0, "b2b_01", 12'h202, 40);
`endif
        tick();
        valid_v[0] = 1'b0;
`ifdef UART_TX_PARITY_EN
        check_frame(0, "b2b_ff", 12'h5FE, 44);
`else
        check_frame(0, "b2b_ff", 12'h3FE, 40);
`endif
        tick();
        chk("b2b_no_third_busy", busy_v[0], 0);

        // Two stop bits, 0x00
        start_frame(1, 8'h00);
`ifdef UART_TX_PARITY_EN
        check_frame(1, "stop2_00", 12'hC00, 48);
`else
        check_frame(1, "stop2_00", 12'h600, 44);
`endif

        // Reset during data bit 3 of 0x55
        start_frame(0, 8'h55);
        for (int c = 0; c < 17; c++) tick();
        chk("abort_pre_bit3", tx_v[0], 0);
        chk("abort_pre_state", st0, DATA);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_tx_async", tx_v[0], 1);
        chk("abort_busy", busy_v[0], 0);
        chk("abort_ready", ready_v[0], 1);
        chk("abort_state", st0, IDLE);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("post_rst_tx_c%0d", c), tx_v[0], 1);
            chk($sformatf("post_rst_busy_c%0d", c), busy_v[0], 0);
            tick();
        end
        start_frame(0, 8'h55);
`ifdef UART_TX_PARITY_EN
        check_frame(0, "fresh_55", 12'h4AA, 44);
`else
        check_frame(0, "fresh_55", 12'h2AA, 40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
